// File: rtl/nw_score_engine.sv
// Needleman-Wunsch / Smith-Waterman score engine: one row buffer, streamed traceback codes.
// Optional macro NW_SATURATE_EN makes every score addition saturate instead of wrapping.
module nw_score_engine #(
    parameter int MAX_LEN = 128,
    parameter int SCORE_W = 10,
    parameter int SYM_W   = 3,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int ADDR_W  = $clog2((MAX_LEN + 1) * (MAX_LEN + 1))
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      mode_local_i,
    input  logic [LEN_W-1:0]          len_a_i,
    input  logic [LEN_W-1:0]          len_b_i,
    input  logic signed [SCORE_W-1:0] match_sc_i,
    input  logic signed [SCORE_W-1:0] mismatch_sc_i,
    input  logic signed [SCORE_W-1:0] gap_sc_i,
    output logic [LEN_W-1:0]          seq_a_addr_o,
    output logic [LEN_W-1:0]          seq_b_addr_o,
    input  logic [SYM_W-1:0]          seq_a_data_i,
    input  logic [SYM_W-1:0]          seq_b_data_i,
    output logic                      dir_valid_o,
    input  logic                      dir_ready_i,
    output logic [ADDR_W-1:0]         dir_addr_o,
    output logic [1:0]                dir_code_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic signed [SCORE_W-1:0] final_score_o,
    output logic [LEN_W-1:0]          best_i_o,
    output logic [LEN_W-1:0]          best_j_o
);

    typedef enum logic [2:0] {IDLE, CHECK, INIT_ROW, ROW_START, FETCH, CALC, DONE} state_t;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_DIAG = 2'b01;
    localparam logic [1:0] DIR_UP   = 2'b10;
    localparam logic [1:0] DIR_LEFT = 2'b11;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    function automatic logic signed [SCORE_W-1:0] satAdd(input logic signed [SCORE_W-1:0] a,
                                                         input logic signed [SCORE_W-1:0] b);
`ifdef NW_SATURATE_EN
        logic signed [SCORE_W:0] sum;
        sum = {a[SCORE_W-1], a} + {b[SCORE_W-1], b};
        if (sum[SCORE_W] != sum[SCORE_W-1])
            return sum[SCORE_W] ? {1'b1, {(SCORE_W-1){1'b0}}} : {1'b0, {(SCORE_W-1){1'b1}}};
        return sum[SCORE_W-1:0];
`else
        return a + b;
`endif
    endfunction

    state_t                     state_q, state_d;
    logic                       mode_q, err_q, busy_q, done_q;
    logic [LEN_W-1:0]           lenA_q, lenB_q, i_q, j_q, aAddr_q;
    logic [SYM_W-1:0]           aSym_q;
    logic signed [SCORE_W-1:0]  matchSc_q, mismatchSc_q, gapSc_q;
    logic signed [SCORE_W-1:0]  left_q, diag_q, rowAcc_q, colAcc_q, best_q;
    logic [LEN_W-1:0]           bestI_q, bestJ_q, finalI_q, finalJ_q;
    logic signed [SCORE_W-1:0]  finalScore_q;
    logic signed [SCORE_W-1:0]  rowBuf_q [0:MAX_LEN];

    logic [LEN_W-1:0]           iNext, cellI, cellJ, bufWAddr;
    logic                       lastRow, dirValid, accept, bufWe, lenBad;
    logic [1:0]                 dirCode, cellCode;
    logic signed [SCORE_W-1:0]  upScore, subSc, candD, candU, candL, cellH, colH, bufWData;

    assign iNext   = i_q + 1'b1;
    assign lastRow = iNext > lenA_q;
    assign lenBad  = (lenA_q > MAX_LEN_L) || (lenB_q > MAX_LEN_L);
    assign upScore = rowBuf_q[j_q];
    assign colH    = mode_q ? '0 : satAdd(colAcc_q, gapSc_q);
    assign accept  = dirValid && dir_ready_i;

    // Interior cell: best of diag/up/left with that tie priority, clamped at 0 in local mode.
    always_comb begin
        subSc    = (aSym_q == seq_b_data_i) ? matchSc_q : mismatchSc_q;
        candD    = satAdd(diag_q, subSc);
        candU    = satAdd(upScore, gapSc_q);
        candL    = satAdd(left_q, gapSc_q);
        cellH    = candD;
        cellCode = DIR_DIAG;
        if (!(candD >= candU && candD >= candL)) begin
            if (candU >= candL) begin
                cellH    = candU;
                cellCode = DIR_UP;
            end else begin
                cellH    = candL;
                cellCode = DIR_LEFT;
            end
        end
        if (mode_q && cellH[SCORE_W-1]) begin
            cellH    = '0;
            cellCode = DIR_STOP;
        end
    end

    always_comb begin
        state_d      = state_q;
        dirValid     = 1'b0;
        dirCode      = DIR_STOP;
        cellI        = '0;
        cellJ        = '0;
        bufWe        = 1'b0;
        bufWAddr     = '0;
        bufWData     = '0;
        seq_a_addr_o = aAddr_q;
        seq_b_addr_o = '0;
        case (state_q)
            IDLE:  if (start_i) state_d = CHECK;
            CHECK: state_d = lenBad ? DONE : INIT_ROW;
            INIT_ROW: begin
                dirValid = 1'b1;
                cellJ    = j_q;
                dirCode  = (j_q == '0 || mode_q) ? DIR_STOP : DIR_LEFT;
                bufWe    = accept;
                bufWAddr = j_q;
                bufWData = mode_q ? '0 : rowAcc_q;
                if (accept && j_q == lenB_q) state_d = ROW_START;
            end
            ROW_START: begin
                seq_a_addr_o = i_q;
                if (lastRow) begin
                    state_d = DONE;
                end else begin
                    dirValid = 1'b1;
                    cellI    = iNext;
                    dirCode  = mode_q ? DIR_STOP : DIR_UP;
                    bufWe    = accept;
                    bufWData = colH;
                    if (accept) state_d = (lenB_q == '0) ? ROW_START : FETCH;
                end
            end
            FETCH: begin
                seq_b_addr_o = j_q - 1'b1;
                state_d      = CALC;
            end
            CALC: begin
                seq_b_addr_o = j_q - 1'b1;
                dirValid     = 1'b1;
                cellI        = i_q;
                cellJ        = j_q;
                dirCode      = cellCode;
                bufWe        = accept;
                bufWAddr     = j_q;
                bufWData     = cellH;
                if (accept) state_d = (j_q == lenB_q) ? ROW_START : FETCH;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Row buffer contents are don't-care after reset, so it stays out of the reset domain.
    always_ff @(posedge clk_i) begin
        if (bufWe) rowBuf_q[bufWAddr] <= bufWData;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;      mode_q <= 1'b0;       err_q <= 1'b0;
            busy_q <= 1'b0;       done_q <= 1'b0;       lenA_q <= '0;
            lenB_q <= '0;         i_q <= '0;            j_q <= '0;
            aAddr_q <= '0;        aSym_q <= '0;         matchSc_q <= '0;
            mismatchSc_q <= '0;   gapSc_q <= '0;        left_q <= '0;
            diag_q <= '0;         rowAcc_q <= '0;       colAcc_q <= '0;
            best_q <= '0;         bestI_q <= '0;        bestJ_q <= '0;
            finalScore_q <= '0;   finalI_q <= '0;       finalJ_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == DONE);
            case (state_q)
                IDLE: if (start_i) begin
                    mode_q       <= mode_local_i;
                    lenA_q       <= len_a_i;
                    lenB_q       <= len_b_i;
                    matchSc_q    <= match_sc_i;
                    mismatchSc_q <= mismatch_sc_i;
                    gapSc_q      <= gap_sc_i;
                    err_q        <= 1'b0;
                    busy_q       <= 1'b1;
                end
                CHECK: begin
                    i_q <= '0;      j_q <= '0;      rowAcc_q <= '0;  colAcc_q <= '0;
                    best_q <= '0;   bestI_q <= '0;  bestJ_q <= '0;   err_q <= lenBad;
                end
                INIT_ROW: if (accept) begin
                    rowAcc_q <= satAdd(rowAcc_q, gapSc_q);
                    j_q      <= j_q + 1'b1;
                end
                ROW_START: if (accept) begin
                    i_q      <= iNext;
                    j_q      <= LEN_W'(1);
                    aAddr_q  <= i_q;
                    colAcc_q <= colH;
                    left_q   <= colH;
                    diag_q   <= rowBuf_q[0];
                end
                FETCH: if (j_q == LEN_W'(1)) aSym_q <= seq_a_data_i;
                CALC: if (accept) begin
                    diag_q <= upScore;
                    left_q <= cellH;
                    j_q    <= j_q + 1'b1;
                    // Strictly greater keeps the first maximum in row-major order.
                    if (mode_q && cellH > best_q) begin
                        best_q  <= cellH;
                        bestI_q <= i_q;
                        bestJ_q <= j_q;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    if (err_q) begin
                        finalScore_q <= '0;     finalI_q <= '0;      finalJ_q <= '0;
                    end else if (mode_q) begin
                        finalScore_q <= best_q; finalI_q <= bestI_q; finalJ_q <= bestJ_q;
                    end else begin
                        finalScore_q <= rowBuf_q[lenB_q];
                        finalI_q     <= lenA_q;
                        finalJ_q     <= lenB_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dir_valid_o   = dirValid;
    assign dir_code_o    = dirValid ? dirCode : DIR_STOP;
    assign dir_addr_o    = ADDR_W'(cellI) * ADDR_W'(MAX_LEN + 1) + ADDR_W'(cellJ);
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign final_score_o = finalScore_q;
    assign best_i_o      = finalI_q;
    assign best_j_o      = finalJ_q;

endmodule

// File: tb/tb_nw_score_engine.sv
// Directed self-checking bench for nw_score_engine: global/local alignments, backpressure,
// zero-length and out-of-range runs, and reset in the middle of a run.
module tb_nw_score_engine;

    localparam int ROW = 129;

    logic              clk, rst_n, start, modeLocal;
    logic [7:0]        lenA, lenB;
    logic signed [9:0] matchSc, mismatchSc, gapSc;
    logic [7:0]        seqAAddr, seqBAddr;
    logic [2:0]        seqAData, seqBData;
    logic              dirValid, dirReady;
    logic [14:0]       dirAddr;
    logic [1:0]        dirCode;
    logic              busy, done, err;
    logic signed [9:0] finalScore;
    logic [7:0]        bestI, bestJ;

    int   checkCount = 0;
    int   errorCount = 0;
    bit   randReady  = 0;
    int   writeCount, orderErrors, holdErrors, doneCount;
    int   expI, expJ, curLenB;
    bit   havePending, gotDone;
    logic [14:0] pAddr;
    logic [1:0]  pCode;
    int   dirMem [0:ROW*ROW-1];
    logic [2:0]  memA [0:255];
    logic [2:0]  memB [0:255];

    nw_score_engine dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_local_i(modeLocal),
        .len_a_i(lenA), .len_b_i(lenB), .match_sc_i(matchSc), .mismatch_sc_i(mismatchSc),
        .gap_sc_i(gapSc), .seq_a_addr_o(seqAAddr), .seq_b_addr_o(seqBAddr),
        .seq_a_data_i(seqAData), .seq_b_data_i(seqBData), .dir_valid_o(dirValid),
        .dir_ready_i(dirReady), .dir_addr_o(dirAddr), .dir_code_o(dirCode), .busy_o(busy),
        .done_o(done), .err_o(err), .final_score_o(finalScore), .best_i_o(bestI), .best_j_o(bestJ)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read sequence memories: data follows the address by one cycle.
    always @(posedge clk) begin
        seqAData <= memA[seqAAddr];
        seqBData <= memB[seqBAddr];
    end

    initial begin
        dirReady = 1'b1;
        forever begin
            @(posedge clk);
            #1 dirReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Direction-stream monitor: records writes, checks row-major order and holding under backpressure.
    initial begin
        forever begin
            @(negedge clk);
            if (done) doneCount++;
            if (havePending) begin
                if (!(dirValid && dirAddr == pAddr && dirCode == pCode)) holdErrors++;
                havePending = 0;
            end
            if (dirValid && dirReady) begin
                writeCount++;
                if (int'(dirAddr) != expI * ROW + expJ) orderErrors++;
                if (expJ == curLenB) begin
                    expI++;
                    expJ = 0;
                end else begin
                    expJ++;
                end
                dirMem[dirAddr] = int'(dirCode);
            end else if (dirValid) begin
                havePending = 1;
                pAddr = dirAddr;
                pCode = dirCode;
            end
        end
    end

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [2:0] symCode(input byte ch);
        case (ch)
            "A":     return 3'd0;
            "C":     return 3'd1;
            "G":     return 3'd2;
            default: return 3'd3;
        endcase
    endfunction

    task automatic loadSeqs(input string a, input string b);
        for (int k = 0; k < a.len(); k++) memA[k] = symCode(a[k]);
        for (int k = 0; k < b.len(); k++) memB[k] = symCode(b[k]);
    endtask

    task automatic startRun(input bit mode, input int la, input int lb,
                            input int m, input int mm, input int g);
        writeCount = 0; orderErrors = 0; holdErrors = 0; doneCount = 0;
        expI = 0; expJ = 0; curLenB = lb; havePending = 0; gotDone = 0;
        for (int k = 0; k < ROW * ROW; k++) dirMem[k] = -1;
        @(posedge clk);
        #1;
        modeLocal = mode; lenA = 8'(la); lenB = 8'(lb);
        matchSc = 10'(m); mismatchSc = 10'(mm); gapSc = 10'(g);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        for (int c = 0; c < 4000 && !gotDone; c++) begin
            @(negedge clk);
            if (done) gotDone = 1;
        end
        checkOutput({tag, ".doneSeen"}, gotDone, 1);
        checkOutput({tag, ".busyAtDone"}, busy, 0);
    endtask

    task automatic applyStimulus(input string tag, input bit mode, input int la, input int lb,
                                 input int m, input int mm, input int g);
        startRun(mode, la, lb, m, mm, g);
        waitDone(tag);
    endtask

    // Expected ACGT/ACGT global codes: diagonal diag, above it left, below it up, origin stop.
    function automatic int acgtDir(input int i, input int j);
        if (i == 0 && j == 0) return 0;
        if (i == j) return 1;
        return (j > i) ? 3 : 2;
    endfunction

    task automatic checkAcgt(input string tag);
        checkOutput({tag, ".final"}, finalScore, 4);
        checkOutput({tag, ".bestI"}, bestI, 4);
        checkOutput({tag, ".bestJ"}, bestJ, 4);
        checkOutput({tag, ".writes"}, writeCount, 25);
        checkOutput({tag, ".order"}, orderErrors, 0);
        checkOutput({tag, ".hold"}, holdErrors, 0);
        for (int i = 0; i <= 4; i++)
            for (int j = 0; j <= 4; j++)
                checkOutput($sformatf("%s.dir(%0d,%0d)", tag, i, j), dirMem[i*ROW+j], acgtDir(i, j));
        @(negedge clk);
        checkOutput({tag, ".donePulse"}, done, 0);
        checkOutput({tag, ".doneCount"}, doneCount, 1);
    endtask

    initial begin
        int borderBad;
        bit found;
        rst_n = 0; start = 0; modeLocal = 0; lenA = 0; lenB = 0;
        matchSc = 0; mismatchSc = 0; gapSc = 0;
        for (int k = 0; k < 256; k++) begin
            memA[k] = 3'd0;
            memB[k] = 3'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.dirValid", dirValid, 0);
        checkOutput("reset.err", err, 0);
        checkOutput("reset.final", finalScore, 0);
        rst_n = 1;

        $display("[TB] global ACGT/ACGT, dir_ready held high");
        loadSeqs("ACGT", "ACGT");
        applyStimulus("acgt", 0, 4, 4, 1, -1, -2);
        checkAcgt("acgt");

        $display("[TB] global A/AG with a start pulse while busy");
        loadSeqs("A", "AG");
        startRun(0, 1, 2, 1, -1, -2);
        @(posedge clk);
        #1 lenA = 8'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone("aag");
        checkOutput("aag.final", finalScore, -1);
        checkOutput("aag.writes", writeCount, 6);
        checkOutput("aag.dir11", dirMem[1*ROW+1], 1);
        checkOutput("aag.dir12", dirMem[1*ROW+2], 3);
        checkOutput("aag.dir10", dirMem[1*ROW+0], 2);
        @(negedge clk);
        checkOutput("aag.doneCount", doneCount, 1);

        $display("[TB] local TTACG/ACGAA");
        loadSeqs("TTACG", "ACGAA");
        applyStimulus("local", 1, 5, 5, 1, -1, -2);
        checkOutput("local.final", finalScore, 3);
        checkOutput("local.bestI", bestI, 5);
        checkOutput("local.bestJ", bestJ, 3);
        checkOutput("local.writes", writeCount, 36);
        checkOutput("local.order", orderErrors, 0);
        borderBad = 0;
        for (int k = 0; k <= 5; k++) begin
            if (dirMem[k] != 0) borderBad++;
            if (dirMem[k*ROW] != 0) borderBad++;
        end
        checkOutput("local.borderStops", borderBad, 0);
        checkOutput("local.dir11", dirMem[1*ROW+1], 0);
        checkOutput("local.dir53", dirMem[5*ROW+3], 1);
        checkOutput("local.dir43zeroLeft", dirMem[4*ROW+3], 3);
        checkOutput("local.dir52zeroUp", dirMem[5*ROW+2], 2);
        checkOutput("local.dir45zeroDiag", dirMem[4*ROW+5], 1);
        checkOutput("local.dir54", dirMem[5*ROW+4], 3);

        $display("[TB] global ACGT/ACGT, dir_ready random");
        loadSeqs("ACGT", "ACGT");
        randReady = 1;
        applyStimulus("acgtRand", 0, 4, 4, 1, -1, -2);
        randReady = 0;
        checkAcgt("acgtRand");

        $display("[TB] out-of-range length");
        applyStimulus("range", 0, 200, 3, 1, -1, -2);
        checkOutput("range.err", err, 1);
        checkOutput("range.writes", writeCount, 0);

        $display("[TB] zero-length sequence A");
        applyStimulus("zero", 0, 0, 3, 1, -1, -2);
        checkOutput("zero.final", finalScore, -6);
        checkOutput("zero.writes", writeCount, 4);
        checkOutput("zero.bestI", bestI, 0);
        checkOutput("zero.bestJ", bestJ, 3);
        checkOutput("zero.dir03", dirMem[3], 3);
        checkOutput("zero.errCleared", err, 0);

        $display("[TB] reset in the middle of a run");
        loadSeqs("ACGT", "ACGT");
        startRun(0, 4, 4, 1, -1, -2);
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (dirValid && dirAddr == 15'(2*ROW+2)) found = 1;
        end
        checkOutput("midReset.reachCalc", found, 1);
        #1 rst_n = 0;
        #1;
        checkOutput("midReset.busy", busy, 0);
        checkOutput("midReset.dirValid", dirValid, 0);
        checkOutput("midReset.final", finalScore, 0);
        @(posedge clk);
        #1 rst_n = 1;
        applyStimulus("afterReset", 0, 4, 4, 1, -1, -2);
        checkAcgt("afterReset");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
